// File: rtl/dm_sb_ctrl.sv
// Debug Module system-bus access sequencer: turns sbaddress0/sbdata0 strobes into
// single 8/16/32-bit bus transactions and tracks sbbusy/sberror/sbbusyerror.
module dm_sb_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [AW-1:0] sbaddress0,
    input  logic          sbaddress0_update,
    input  logic          sbreadonaddr,
    input  logic [DW-1:0] sbdata0,
    input  logic          sbdata0_update,
    input  logic          sbdata0_rd,
    input  logic [2:0]    sbaccess,
    input  logic [2:0]    sberror_w1,
    input  logic          sbbusyerror_w1,
    output logic          sbbusy,
    output logic [2:0]    sberror,
    output logic          sbbusyerror,
    output logic [DW-1:0] system_bus_read_data,
    output logic          system_bus_read_data_valid,
    output logic          m_req_valid,
    input  logic          m_req_ready,
    output logic          m_req_wr,
    output logic [AW-1:0] m_req_addr,
    output logic [3:0]    m_req_be,
    output logic [DW-1:0] m_req_wdata,
    input  logic          m_resp_valid,
    input  logic [DW-1:0] m_resp_rdata,
    input  logic          m_resp_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic [1:0]    alo_q;

    logic read_trig, write_trig, trig, misaligned, timed_out;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] lane_wdata(input logic [1:0] size, input logic [DW-1:0] d);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DW-1:0] lane_rdata(input logic [1:0] size, input logic [1:0] a,
                                                 input logic [DW-1:0] rd);
        logic [DW-1:0] sh;
        sh = rd >> {a, 3'b000};
        case (size)
            2'd0:    return {{(DW-8){1'b0}}, sh[7:0]};
            2'd1:    return {{(DW-16){1'b0}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign read_trig  = sbdata0_rd | (sbaddress0_update & sbreadonaddr);
    assign write_trig = sbdata0_update;
    assign trig       = read_trig | write_trig;
    assign misaligned = ((sbaccess[1:0] == 2'd1) && sbaddress0[0]) ||
                        ((sbaccess[1:0] == 2'd2) && (sbaddress0[1:0] != 2'b00));
    // Saturating compare: a late REQ handshake can push cnt one past the limit.
    assign timed_out  = (cnt >= CW'(TIMEOUT - 1));
    assign sbbusy     = (state != IDLE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state                      <= IDLE;
            cnt                        <= '0;
            size_q                     <= '0;
            alo_q                      <= '0;
            sberror                    <= '0;
            sbbusyerror                <= 1'b0;
            system_bus_read_data       <= '0;
            system_bus_read_data_valid <= 1'b0;
            m_req_valid                <= 1'b0;
            m_req_wr                   <= 1'b0;
            m_req_addr                 <= '0;
            m_req_be                   <= '0;
            m_req_wdata                <= '0;
        end else begin
            system_bus_read_data_valid <= 1'b0;
            // Clears first; any set below overrides them in the same cycle.
            sberror     <= sberror & ~sberror_w1;
            sbbusyerror <= sbbusyerror & ~sbbusyerror_w1;
            if (state != IDLE && trig) sbbusyerror <= 1'b1;

            case (state)
                IDLE: begin
                    if (trig && sberror == 3'd0 && !sbbusyerror) begin
                        if (sbaccess > 3'd2) begin
                            sberror <= 3'h4;
                        end else if (misaligned) begin
                            sberror <= 3'h3;
                        end else begin
                            state       <= REQ;
                            cnt         <= '0;
                            size_q      <= sbaccess[1:0];
                            alo_q       <= sbaddress0[1:0];
                            m_req_valid <= 1'b1;
                            m_req_wr    <= write_trig;
                            m_req_addr  <= sbaddress0;
                            m_req_be    <= lane_be(sbaccess[1:0], sbaddress0[1:0]);
                            m_req_wdata <= lane_wdata(sbaccess[1:0], sbdata0);
                        end
                    end
                end
                REQ: begin
                    if (m_req_ready) begin
                        m_req_valid <= 1'b0;
                        state       <= RESP;
                        cnt         <= cnt + 1'b1;
                    end else if (timed_out) begin
                        m_req_valid <= 1'b0;
                        state       <= IDLE;
                        sberror     <= 3'h1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (m_resp_valid) begin
                        state <= IDLE;
                        if (m_resp_err) begin
                            sberror <= 3'h2;
                        end else if (!m_req_wr) begin
                            system_bus_read_data_valid <= 1'b1;
                            system_bus_read_data       <= lane_rdata(size_q, alo_q, m_resp_rdata);
                        end
                    end else if (timed_out) begin
                        state   <= IDLE;
                        sberror <= 3'h1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_sb_ctrl.sv
// Directed bench for dm_sb_ctrl: a vector table of single accesses plus
// hand-written sequences for sticky errors, busy errors, timeout and reset.
module tb_dm_sb_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] sbaddress0;
    logic        sbaddress0_update;
    logic        sbreadonaddr;
    logic [31:0] sbdata0;
    logic        sbdata0_update;
    logic        sbdata0_rd;
    logic [2:0]  sbaccess;
    logic [2:0]  sberror_w1;
    logic        sbbusyerror_w1;
    logic        sbbusy;
    logic [2:0]  sberror;
    logic        sbbusyerror;
    logic [31:0] system_bus_read_data;
    logic        system_bus_read_data_valid;
    logic        m_req_valid;
    logic        m_req_ready;
    logic        m_req_wr;
    logic [31:0] m_req_addr;
    logic [3:0]  m_req_be;
    logic [31:0] m_req_wdata;
    logic        m_resp_valid;
    logic [31:0] m_resp_rdata;
    logic        m_resp_err;

    int checks   = 0;
    int failures = 0;

    dm_sb_ctrl #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .sbaddress0(sbaddress0), .sbaddress0_update(sbaddress0_update),
        .sbreadonaddr(sbreadonaddr), .sbdata0(sbdata0),
        .sbdata0_update(sbdata0_update), .sbdata0_rd(sbdata0_rd),
        .sbaccess(sbaccess), .sberror_w1(sberror_w1), .sbbusyerror_w1(sbbusyerror_w1),
        .sbbusy(sbbusy), .sberror(sberror), .sbbusyerror(sbbusyerror),
        .system_bus_read_data(system_bus_read_data),
        .system_bus_read_data_valid(system_bus_read_data_valid),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_wr(m_req_wr),
        .m_req_addr(m_req_addr), .m_req_be(m_req_be), .m_req_wdata(m_req_wdata),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err)
    );

    always #5 sys_clk = ~sys_clk;

    // kind: 0 = write (sbdata0_update), 1 = read (sbdata0_rd), 2 = read on address write
    typedef struct {
        int          kind;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rresp;
        logic        rerr;
        logic [2:0]  imm_err;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic        pulse;
        logic [31:0] exp_rdata;
        logic [2:0]  fin_err;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic trigger(input int kind, input logic [2:0] acc, input logic [31:0] addr,
                           input logic [31:0] wd);
        sbaccess   = acc;
        sbaddress0 = addr;
        sbdata0    = wd;
        sbdata0_update    = (kind == 0);
        sbdata0_rd        = (kind == 1);
        sbaddress0_update = (kind == 2);
        sbreadonaddr      = (kind == 2);
        tick();
        sbdata0_update    = 1'b0;
        sbdata0_rd        = 1'b0;
        sbaddress0_update = 1'b0;
        sbreadonaddr      = 1'b0;
    endtask

    task automatic clear_errs();
        sberror_w1     = 3'b111;
        sbbusyerror_w1 = 1'b1;
        tick();
        sberror_w1     = 3'b000;
        sbbusyerror_w1 = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        trigger(v.kind, v.acc, v.addr, v.wdata);
        if (v.imm_err != 3'd0) begin
            chk($sformatf("v%0d_noreq", idx), {31'b0, m_req_valid}, 32'd0);
            chk($sformatf("v%0d_busy", idx), {31'b0, sbbusy}, 32'd0);
            chk($sformatf("v%0d_immerr", idx), {29'b0, sberror}, {29'b0, v.imm_err});
            clear_errs();
            chk($sformatf("v%0d_errclr", idx), {29'b0, sberror}, 32'd0);
            return;
        end
        chk($sformatf("v%0d_reqv", idx), {31'b0, m_req_valid}, 32'd1);
        chk($sformatf("v%0d_busy", idx), {31'b0, sbbusy}, 32'd1);
        chk($sformatf("v%0d_wr", idx), {31'b0, m_req_wr}, (v.kind == 0) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_addr", idx), m_req_addr, v.addr);
        chk($sformatf("v%0d_be", idx), {28'b0, m_req_be}, {28'b0, v.be});
        if (v.kind == 0) chk($sformatf("v%0d_wdata", idx), m_req_wdata, v.exp_wdata);
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        chk($sformatf("v%0d_reqdrop", idx), {31'b0, m_req_valid}, 32'd0);
        tick();
        tick();
        chk($sformatf("v%0d_busyresp", idx), {31'b0, sbbusy}, 32'd1);
        m_resp_valid = 1'b1;
        m_resp_rdata = v.rresp;
        m_resp_err   = v.rerr;
        tick();
        m_resp_valid = 1'b0;
        m_resp_err   = 1'b0;
        chk($sformatf("v%0d_done", idx), {31'b0, sbbusy}, 32'd0);
        chk($sformatf("v%0d_pulse", idx), {31'b0, system_bus_read_data_valid}, {31'b0, v.pulse});
        if (v.pulse) chk($sformatf("v%0d_rdata", idx), system_bus_read_data, v.exp_rdata);
        chk($sformatf("v%0d_sberr", idx), {29'b0, sberror}, {29'b0, v.fin_err});
        tick();
        chk($sformatf("v%0d_pulse1", idx), {31'b0, system_bus_read_data_valid}, 32'd0);
        if (v.fin_err != 3'd0) clear_errs();
    endtask

    initial begin
        //           kind acc   addr          wdata         rresp         err imm   be       exp_wdata     pls exp_rdata     fin
        vecs[0]  = '{1, 3'd2, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 0, 3'd0, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF, 3'd0};
        vecs[1]  = '{0, 3'd0, 32'h0000_1003, 32'h0000_005A, 32'h0,        0, 3'd0, 4'b1000, 32'h5A5A_5A5A, 0, 32'h0,        3'd0};
        vecs[2]  = '{1, 3'd1, 32'h0000_1001, 32'h0,        32'h0,        0, 3'd3, 4'b0000, 32'h0,        0, 32'h0,        3'd0};
        vecs[3]  = '{2, 3'd0, 32'h0000_2001, 32'h0,        32'h1122_3344, 0, 3'd0, 4'b0010, 32'h0,        1, 32'h0000_0033, 3'd0};
        vecs[4]  = '{1, 3'd1, 32'h0000_2002, 32'h0,        32'hCAFE_F00D, 0, 3'd0, 4'b1100, 32'h0,        1, 32'h0000_CAFE, 3'd0};
        vecs[5]  = '{0, 3'd1, 32'h0000_3000, 32'h1234_ABCD, 32'h0,        0, 3'd0, 4'b0011, 32'hABCD_ABCD, 0, 32'h0,        3'd0};
        vecs[6]  = '{0, 3'd2, 32'h0000_4000, 32'hA5A5_0F0F, 32'h0,        0, 3'd0, 4'b1111, 32'hA5A5_0F0F, 0, 32'h0,        3'd0};
        vecs[7]  = '{1, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        0, 3'd4, 4'b0000, 32'h0,        0, 32'h0,        3'd0};
        vecs[8]  = '{0, 3'd2, 32'h0000_4002, 32'h1,        32'h0,        0, 3'd3, 4'b0000, 32'h0,        0, 32'h0,        3'd0};
        vecs[9]  = '{1, 3'd2, 32'h0000_6000, 32'h0,        32'hFFFF_FFFF, 1, 3'd0, 4'b1111, 32'h0,        0, 32'h0,        3'd2};
        vecs[10] = '{2, 3'd0, 32'h0000_5000, 32'h0,        32'h0000_00AB, 0, 3'd0, 4'b0001, 32'h0,        1, 32'h0000_00AB, 3'd0};

        sys_rst = 1'b1;
        sbaddress0 = '0; sbaddress0_update = 1'b0; sbreadonaddr = 1'b0;
        sbdata0 = '0; sbdata0_update = 1'b0; sbdata0_rd = 1'b0; sbaccess = 3'd2;
        sberror_w1 = 3'd0; sbbusyerror_w1 = 1'b0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_rdata = '0; m_resp_err = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'b0, sbbusy}, 32'd0);
        chk("rst_sberr", {29'b0, sberror}, 32'd0);
        chk("rst_reqv", {31'b0, m_req_valid}, 32'd0);
        chk("rst_rdata", system_bus_read_data, 32'd0);
        sys_rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec(i);

        // Sticky error blocks triggers; set beats a same-cycle clear.
        sberror_w1 = 3'b111;
        trigger(1, 3'd1, 32'h0000_1001, 32'h0);
        sberror_w1 = 3'b000;
        chk("setwins_sberr", {29'b0, sberror}, 32'd3);
        trigger(1, 3'd2, 32'h0000_0100, 32'h0);
        chk("sticky_noreq", {31'b0, m_req_valid}, 32'd0);
        chk("sticky_nobusyerr", {31'b0, sbbusyerror}, 32'd0);
        sberror_w1 = 3'b001;
        tick();
        sberror_w1 = 3'b000;
        chk("partial_clr", {29'b0, sberror}, 32'd2);
        clear_errs();
        chk("sticky_clr", {29'b0, sberror}, 32'd0);

        // Trigger while busy in RESP: busy error, first access completes.
        trigger(0, 3'd2, 32'h0000_7000, 32'h1357_9BDF);
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        trigger(0, 3'd2, 32'h0000_7004, 32'h0);
        chk("busyerr_set", {31'b0, sbbusyerror}, 32'd1);
        chk("busyerr_noreq", {31'b0, m_req_valid}, 32'd0);
        chk("busyerr_addr", m_req_addr, 32'h0000_7000);
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0;
        chk("busyerr_done", {31'b0, sbbusy}, 32'd0);
        chk("busyerr_sberr", {29'b0, sberror}, 32'd0);
        trigger(0, 3'd2, 32'h0000_7008, 32'h0);
        chk("busyerr_blocks", {31'b0, m_req_valid}, 32'd0);
        sbbusyerror_w1 = 1'b1;
        tick();
        sbbusyerror_w1 = 1'b0;
        chk("busyerr_clr", {31'b0, sbbusyerror}, 32'd0);

        // Timeout with ready never asserted (TIMEOUT=16).
        trigger(1, 3'd2, 32'h0000_8000, 32'h0);
        chk("to_reqv", {31'b0, m_req_valid}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_still_busy", {31'b0, sbbusy}, 32'd1);
        chk("to_no_err_yet", {29'b0, sberror}, 32'd0);
        tick();
        chk("to_idle", {31'b0, sbbusy}, 32'd0);
        chk("to_sberr", {29'b0, sberror}, 32'd1);
        chk("to_reqdrop", {31'b0, m_req_valid}, 32'd0);
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'h1234_5678;
        tick();
        m_resp_valid = 1'b0;
        chk("stray_nopulse", {31'b0, system_bus_read_data_valid}, 32'd0);
        chk("stray_sberr", {29'b0, sberror}, 32'd1);
        clear_errs();

        // Reset during REQ aborts the access.
        trigger(1, 3'd2, 32'h0000_9000, 32'h0);
        chk("rstmid_reqv", {31'b0, m_req_valid}, 32'd1);
        sys_rst = 1'b1;
        tick();
        chk("rstmid_reqv0", {31'b0, m_req_valid}, 32'd0);
        chk("rstmid_busy", {31'b0, sbbusy}, 32'd0);
        chk("rstmid_addr", m_req_addr, 32'd0);
        chk("rstmid_be", {28'b0, m_req_be}, 32'd0);
        sys_rst = 1'b0;
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0;
        chk("rstmid_drop", {31'b0, system_bus_read_data_valid}, 32'd0);
        chk("rstmid_sberr", {29'b0, sberror}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
